data_mem_ctrl: RTL and testbench
================================

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter DEPTH_BYTES, default 64: byte capacity; power of two, >= 4.
REQ-002 SHALL have parameter BASE_ADDR, default 1024: byte address of offset 0.
REQ-003 SHALL have parameter WAIT_CYCLES, default 1: added access wait states, range 0..15.
REQ-004 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port req, input, 1: access request, sampled only while ready=1.
REQ-007 SHALL have port we, input, 1: 1 = write, 0 = read.
REQ-008 SHALL have port size, input, 2: 00 byte, 01 half, 10 word, 11 reserved.
REQ-009 SHALL have port addr, input, 32: byte address.
REQ-010 SHALL have port wdata, input, 32: write data, right-justified for byte/half.
REQ-011 SHALL have port ready, output, 1: 1 only in IDLE; request accepted on edge with req&ready.
REQ-012 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-013 SHALL have port rdata, output, 32: read data, zero-extended.
REQ-014 SHALL have port err, output, 1: error flag, valid only with done.

Function
REQ-015 SHALL implement FSM IDLE -> WAIT (WAIT_CYCLES>0) or RESP (WAIT_CYCLES=0) on acceptance; WAIT -> RESP after WAIT_CYCLES cycles; RESP -> IDLE unconditionally.
REQ-016 SHALL register addr, we, size and wdata at acceptance; later input changes are ignored.
REQ-017 SHALL assert done exactly WAIT_CYCLES+1 cycles after the acceptance edge, for one cycle (RESP).
REQ-018 SHALL ignore req while ready=0; no queuing.
REQ-019 SHALL compute offset = addr - BASE_ADDR, truncated to log2(DEPTH_BYTES) bits.
REQ-020 SHALL store big-endian: lowest address holds the most significant byte of the accessed unit.
REQ-021 SHALL commit writes and capture read data into rdata on the edge entering RESP.
REQ-022 SHALL leave rdata unchanged on write completion; rdata updates only on read completion.
REQ-023 SHALL place a byte read in rdata[7:0] and a half read in rdata[15:0], upper bits zero.

Reset
REQ-024 SHALL on rst_n low force IDLE, ready=1, done=0, err=0, rdata=0, wait counter=0.
REQ-025 SHALL abort an in-flight access on reset; no write commits if reset precedes the commit edge.
REQ-026 SHALL NOT initialise or clear memory contents on reset.

Configuration
REQ-027 SHALL with MEM_ERR_CHECK_EN defined flag err=1 for: addr < BASE_ADDR, access end beyond BASE_ADDR+DEPTH_BYTES, half with addr[0]=1, word with addr[1:0]!=0, size=11.
REQ-028 SHALL with MEM_ERR_CHECK_EN on an error suppress the write, return rdata=0, keep normal done timing.
REQ-029 SHALL without MEM_ERR_CHECK_EN tie err=0, wrap byte indices modulo DEPTH_BYTES, skip alignment checks, treat size=11 as word.

Structure
REQ-030 SHALL take size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and FSM state encoding from shared package mem_pkg.
REQ-031 SHALL place the byte array with big-endian lane read/write in sub-module mem_byte_array; FSM, counter and error logic stay in data_mem_ctrl.

Verification
REQ-032 SHALL cover: WAIT_CYCLES=1, word write 0xDEADBEEF @1024, then word read @1024 -> done 2 cycles after each accept, rdata=0xDEADBEEF; byte read @1024 -> 0x000000DE.
REQ-033 SHALL cover: half write 0xABCD @1030, word read @1028 -> rdata[15:0]=0xABCD, other bytes unchanged.
REQ-034 SHALL cover with MEM_ERR_CHECK_EN: word read @1026 and byte read @1023 -> err=1, rdata=0; word write @1026 -> memory unchanged; without the macro word read @1088 returns offset-0 data, err=0.
REQ-035 SHALL cover: req held high 6 cycles -> exactly two accesses at WAIT_CYCLES=1, ready=0 in WAIT/RESP.
REQ-036 SHALL cover: rst_n low during WAIT of write 0x11223344 @1032 -> no done, word @1032 unchanged, ready=1 after release.
REQ-037 SHALL cover: WAIT_CYCLES=0 -> done 1 cycle after acceptance, throughput one access per 2 cycles.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings for the data memory controller: access sizes, FSM states
// and the byte count of each access size.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_WAIT = 2'b01;
  localparam logic [1:0] ST_RESP = 2'b10;

  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      SZ_BYTE: size_bytes = 3'd1;
      SZ_HALF: size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_byte_array.sv
// Byte-addressed storage with big-endian lanes: the lowest byte index holds
// the most significant byte of the unit. Indices wrap modulo the depth.
module mem_byte_array
  import mem_pkg::*;
#(
  parameter int DEPTH_BYTES = 64
) (
  input  logic                           i_clk,
  input  logic                           i_we,
  input  logic [1:0]                     i_size,
  input  logic [$clog2(DEPTH_BYTES)-1:0] i_offset,
  input  logic [31:0]                    i_wdata,
  output logic [31:0]                    o_rdata
);

  localparam int AW = $clog2(DEPTH_BYTES);

  logic [7:0]    r_mem [DEPTH_BYTES];
  logic [AW-1:0] w_i0, w_i1, w_i2, w_i3;

  assign w_i0 = i_offset;
  assign w_i1 = i_offset + AW'(1);
  assign w_i2 = i_offset + AW'(2);
  assign w_i3 = i_offset + AW'(3);

  always_comb begin
    case (i_size)
      SZ_BYTE: o_rdata = {24'h0, r_mem[w_i0]};
      SZ_HALF: o_rdata = {16'h0, r_mem[w_i0], r_mem[w_i1]};
      default: o_rdata = {r_mem[w_i0], r_mem[w_i1], r_mem[w_i2], r_mem[w_i3]};
    endcase
  end

  // Contents are deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      case (i_size)
        SZ_BYTE: r_mem[w_i0] <= i_wdata[7:0];
        SZ_HALF: begin
          r_mem[w_i0] <= i_wdata[15:8];
          r_mem[w_i1] <= i_wdata[7:0];
        end
        default: begin
          r_mem[w_i0] <= i_wdata[31:24];
          r_mem[w_i1] <= i_wdata[23:16];
          r_mem[w_i2] <= i_wdata[15:8];
          r_mem[w_i3] <= i_wdata[7:0];
        end
      endcase
    end
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data memory controller: IDLE/WAIT/RESP access FSM with programmable wait
// states. Define MEM_ERR_CHECK_EN to enable range/alignment/size error checks.
module data_mem_ctrl
  import mem_pkg::*;
#(
  parameter int DEPTH_BYTES = 64,
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err,
  output logic [1:0]  dbg_state
);

  localparam int         AW        = $clog2(DEPTH_BYTES);
  localparam logic [3:0] WAIT_LAST = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  logic [1:0]    r_state;
  logic [3:0]    r_cnt;
  logic          r_we;
  logic [1:0]    r_size;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [31:0]   r_rdata;
  logic          r_err;

  logic          w_idle, w_accept, w_enter_resp, w_err, w_mem_we;
  logic          w_a_we;
  logic [1:0]    w_a_size;
  logic [31:0]   w_a_addr, w_a_wdata, w_off_full, w_mem_rdata;

  // req/ready: a request is taken on a rising edge where req & ready are both
  // high; ready is high only in IDLE and req is ignored otherwise (no queue).
  assign w_idle   = (r_state == ST_IDLE);
  assign w_accept = w_idle & req;

  // With zero wait states the commit edge is the acceptance edge itself, so
  // the live inputs stand in for the not-yet-captured registers.
  assign w_a_we    = w_idle ? we    : r_we;
  assign w_a_size  = w_idle ? size  : r_size;
  assign w_a_addr  = w_idle ? addr  : r_addr;
  assign w_a_wdata = w_idle ? wdata : r_wdata;

  assign w_off_full   = w_a_addr - 32'(BASE_ADDR);
  assign w_enter_resp = (w_accept && (WAIT_CYCLES == 0)) ||
                        ((r_state == ST_WAIT) && (r_cnt == WAIT_LAST));
  assign w_mem_we     = w_enter_resp & w_a_we & ~w_err;

`ifdef MEM_ERR_CHECK_EN
  logic [2:0] w_nbytes;
  assign w_nbytes = size_bytes(w_a_size);
  assign w_err = (w_a_addr < 32'(BASE_ADDR)) ||
                 (w_off_full > (32'(DEPTH_BYTES) - 32'(w_nbytes))) ||
                 ((w_a_size == SZ_HALF) && w_a_addr[0]) ||
                 ((w_a_size == SZ_WORD) && (w_a_addr[1:0] != 2'b00)) ||
                 (w_a_size == SZ_RSVD);
`else
  logic w_unused_hi;
  assign w_unused_hi = ^w_off_full[31:AW];
  assign w_err       = 1'b0;
`endif

  mem_byte_array #(.DEPTH_BYTES(DEPTH_BYTES)) u_array (
    .i_clk    (clk),
    .i_we     (w_mem_we),
    .i_size   (w_a_size),
    .i_offset (w_off_full[AW-1:0]),
    .i_wdata  (w_a_wdata),
    .o_rdata  (w_mem_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_size  <= SZ_BYTE;
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
      r_rdata <= 32'h0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req) begin
            r_we    <= we;
            r_size  <= size;
            r_addr  <= addr;
            r_wdata <= wdata;
            r_cnt   <= 4'd0;
            r_state <= (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (r_cnt == WAIT_LAST) r_state <= ST_RESP;
          else                    r_cnt   <= r_cnt + 4'd1;
        end
        default: r_state <= ST_IDLE;
      endcase

      if (w_enter_resp) begin
        r_err <= w_err;
        if (!w_a_we) r_rdata <= w_err ? 32'h0 : w_mem_rdata;
      end
    end
  end

  assign ready     = w_idle;
  assign done      = (r_state == ST_RESP);
  assign err       = done & r_err;
  assign rdata     = r_rdata;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: one instance with one wait state and one
// with none, sharing clock and reset. Honours MEM_ERR_CHECK_EN.
module tb_data_mem_ctrl;
  import mem_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // index 0: WAIT_CYCLES=0, index 1: WAIT_CYCLES=1
  logic [1:0]       req, we, ready, done, err;
  logic [1:0][1:0]  size, dbg;
  logic [1:0][31:0] addr, wdata, rdata;

  int n_checks = 0;
  int n_errors = 0;

  data_mem_ctrl #(.DEPTH_BYTES(64), .BASE_ADDR(1024), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req(req[0]), .we(we[0]), .size(size[0]),
    .addr(addr[0]), .wdata(wdata[0]), .ready(ready[0]), .done(done[0]),
    .rdata(rdata[0]), .err(err[0]), .dbg_state(dbg[0])
  );

  data_mem_ctrl #(.DEPTH_BYTES(64), .BASE_ADDR(1024), .WAIT_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req(req[1]), .we(we[1]), .size(size[1]),
    .addr(addr[1]), .wdata(wdata[1]), .ready(ready[1]), .done(done[1]),
    .rdata(rdata[1]), .err(err[1]), .dbg_state(dbg[1])
  );

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before 200000");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- drivers ----------------
  // One access on instance s; inputs are scrambled right after acceptance.
  // lat counts edges after the acceptance edge until done is seen.
  task automatic access(input int s, input logic w, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic e, output int lat);
    req[s] = 1'b1; we[s] = w; size[s] = sz; addr[s] = a; wdata[s] = wd;
    @(posedge clk); #1;
    req[s] = 1'b0; we[s] = ~w; size[s] = SZ_BYTE;
    addr[s] = 32'h0000_0000; wdata[s] = 32'h5A5A_5A5A;
    lat = 0;
    while (!done[s] && lat < 16) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = rdata[s];
    e  = err[s];
    @(posedge clk); #1;
  endtask

  task automatic wr(input int s, input logic [1:0] sz, input logic [31:0] a,
                    input logic [31:0] wd, input string tag);
    logic [31:0] rd; logic e; int lat;
    access(s, 1'b1, sz, a, wd, rd, e, lat);
    check({tag, "_lat"}, 32'(lat), 32'(s));
    check({tag, "_err"}, {31'h0, e}, 32'h0);
  endtask

  task automatic rd_chk(input int s, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] exp_d, input logic exp_e, input string tag);
    logic [31:0] rd; logic e; int lat;
    access(s, 1'b0, sz, a, 32'h0, rd, e, lat);
    check({tag, "_lat"}, 32'(lat), 32'(s));
    check({tag, "_data"}, rd, exp_d);
    check({tag, "_err"}, {31'h0, e}, {31'h0, exp_e});
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] t_rd;
    logic        t_e;
    int          t_lat;
    int          n_done;
    logic [5:0]  exp_rdy;

    req = '0; we = '0; size = '0; addr = '0; wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready1", {31'h0, ready[1]}, 32'h1);
    check("rst_done1",  {31'h0, done[1]},  32'h0);
    check("rst_err1",   {31'h0, err[1]},   32'h0);
    check("rst_rdata1", rdata[1],          32'h0);
    check("rst_state1", {30'h0, dbg[1]},   {30'h0, ST_IDLE});
    check("rst_ready0", {31'h0, ready[0]}, 32'h1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // basic word/byte/half traffic, one wait state
    wr(1, SZ_WORD, 32'd1024, 32'hDEADBEEF, "w1024");
    rd_chk(1, SZ_WORD, 32'd1024, 32'hDEADBEEF, 1'b0, "rw1024");
    rd_chk(1, SZ_BYTE, 32'd1024, 32'h000000DE, 1'b0, "rb1024");
    rd_chk(1, SZ_BYTE, 32'd1027, 32'h000000EF, 1'b0, "rb1027");
    wr(1, SZ_WORD, 32'd1028, 32'h01020304, "w1028");
    wr(1, SZ_HALF, 32'd1030, 32'h0000ABCD, "wh1030");
    check("rdata_hold_on_write", rdata[1], 32'h000000EF);
    rd_chk(1, SZ_WORD, 32'd1028, 32'h0102ABCD, 1'b0, "rw1028");
    rd_chk(1, SZ_HALF, 32'd1030, 32'h0000ABCD, 1'b0, "rh1030");

`ifdef MEM_ERR_CHECK_EN
    rd_chk(1, SZ_WORD, 32'd1026, 32'h0, 1'b1, "err_unal_word");
    rd_chk(1, SZ_BYTE, 32'd1023, 32'h0, 1'b1, "err_below_base");
    rd_chk(1, SZ_HALF, 32'd1025, 32'h0, 1'b1, "err_unal_half");
    rd_chk(1, SZ_WORD, 32'd1086, 32'h0, 1'b1, "err_past_end");
    rd_chk(1, SZ_RSVD, 32'd1024, 32'h0, 1'b1, "err_rsvd");
    access(1, 1'b1, SZ_WORD, 32'd1026, 32'hFFFFFFFF, t_rd, t_e, t_lat);
    check("err_wr_lat", 32'(t_lat), 32'd1);
    check("err_wr_err", {31'h0, t_e}, 32'h1);
    rd_chk(1, SZ_WORD, 32'd1024, 32'hDEADBEEF, 1'b0, "err_wr_keep0");
    rd_chk(1, SZ_WORD, 32'd1028, 32'h0102ABCD, 1'b0, "err_wr_keep1");
    wr(1, SZ_WORD, 32'd1084, 32'hA1B2C3D4, "w_last");
    rd_chk(1, SZ_WORD, 32'd1084, 32'hA1B2C3D4, 1'b0, "r_last");
`else
    rd_chk(1, SZ_WORD, 32'd1088, 32'hDEADBEEF, 1'b0, "wrap_1088");
    rd_chk(1, SZ_RSVD, 32'd1024, 32'hDEADBEEF, 1'b0, "rsvd_as_word");
    rd_chk(1, SZ_WORD, 32'd1026, 32'hBEEF0102, 1'b0, "unal_word");
    wr(1, SZ_BYTE, 32'd1086, 32'h00000011, "wb1086");
    wr(1, SZ_BYTE, 32'd1087, 32'h00000022, "wb1087");
    rd_chk(1, SZ_WORD, 32'd1086, 32'h1122DEAD, 1'b0, "wrap_word");
`endif

    // req held high for six edges, one wait state
    req[1] = 1'b1; we[1] = 1'b0; size[1] = SZ_WORD; addr[1] = 32'd1024;
    exp_rdy = 6'b100100;
    n_done = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check($sformatf("burst1_ready%0d", i), {31'h0, ready[1]}, {31'h0, exp_rdy[i]});
      if (done[1]) n_done++;
    end
    req[1] = 1'b0;
    check("burst1_dones", 32'(n_done), 32'd2);
    check("burst1_rdata", rdata[1], 32'hDEADBEEF);

    // reset during WAIT of a write
    wr(1, SZ_WORD, 32'd1032, 32'h55667788, "w1032");
    req[1] = 1'b1; we[1] = 1'b1; size[1] = SZ_WORD; addr[1] = 32'd1032; wdata[1] = 32'h11223344;
    @(posedge clk); #1;
    req[1] = 1'b0;
    check("abort_in_wait", {30'h0, dbg[1]}, {30'h0, ST_WAIT});
    rst_n = 1'b0;
    #1;
    check("abort_ready", {31'h0, ready[1]}, 32'h1);
    check("abort_done",  {31'h0, done[1]},  32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (done[1]) n_done++;
    end
    check("abort_no_done", 32'(n_done), 32'd0);
    check("abort_ready_after", {31'h0, ready[1]}, 32'h1);
    rd_chk(1, SZ_WORD, 32'd1032, 32'h55667788, 1'b0, "abort_unchanged");
    rd_chk(1, SZ_WORD, 32'd1024, 32'hDEADBEEF, 1'b0, "mem_kept_on_reset");

    // zero wait states
    wr(0, SZ_WORD, 32'd1024, 32'hCAFEF00D, "z_w1024");
    rd_chk(0, SZ_WORD, 32'd1024, 32'hCAFEF00D, 1'b0, "z_rw1024");
    rd_chk(0, SZ_HALF, 32'd1026, 32'h0000F00D, 1'b0, "z_rh1026");
    req[0] = 1'b1; we[0] = 1'b0; size[0] = SZ_BYTE; addr[0] = 32'd1025;
    exp_rdy = 6'b101010;
    n_done = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check($sformatf("burst0_ready%0d", i), {31'h0, ready[0]}, {31'h0, exp_rdy[i]});
      if (done[0]) n_done++;
    end
    req[0] = 1'b0;
    check("burst0_dones", 32'(n_done), 32'd3);
    check("burst0_rdata", rdata[0], 32'h000000FE);

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
